// File: rtl/uart_tx.sv
// Buffered UART transmitter: a small FIFO feeds an asynchronous-frame serialiser,
// LSB first, with optional parity and frame starts gated by a synchronised CTS#.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD_BPS   = 9600,
    parameter int BAUD_COUNT = CLK_HZ / BAUD_BPS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          cts_n,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_COUNT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_COUNT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Odd parity makes the total count of ones (data + parity) odd.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            return ~^d;
        end
        return ^d;
    endfunction

    logic                 cts_meta_p0;
    logic                 cts_sync;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count_next;
    logic                 push;
    logic                 pop;

    state_t               state;
    state_t               state_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 par_bit;
    logic                 par_next;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BAUD_W-1:0]    baud_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_next;
    logic                 stop_cnt;
    logic                 stop_next;
    logic                 txd_next;
    logic                 bit_end;
    logic                 can_start;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cts_meta_p0 <= 1'b1;
            cts_sync    <= 1'b1;
        end else begin
            cts_meta_p0 <= cts_n;
            cts_sync    <= cts_meta_p0;
        end
    end

    assign push = in_valid & in_ready;

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_next = fifo_count - 1'b1;
        end
    end

    // in_ready is a flop so the producer never sees a path through the FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_ready   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_next;
            in_ready   <= (count_next != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
        shift   <= shift_next;
        par_bit <= par_next;
    end

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign can_start = (fifo_count != '0) && !cts_sync;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_next = state;
        shift_next = shift;
        par_next   = par_bit;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        stop_next  = stop_cnt;
        pop        = 1'b0;
        txd_next   = 1'b1;

        if (state != S_IDLE) begin
            baud_next = bit_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (can_start) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    par_next   = parity_of(mem[rd_ptr]);
                    baud_next  = '0;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_next   = '0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        stop_next  = 1'b0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        shift_next = shift >> 1;
                        bit_next   = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    stop_next  = 1'b0;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_cnt != STOP_LAST) begin
                        stop_next = 1'b1;
                    end else if (can_start) begin
                        // Chain straight into the next start bit with no idle cycle.
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        par_next   = parity_of(mem[rd_ptr]);
                        baud_next  = '0;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        case (state_next)
            S_START:  txd_next = 1'b0;
            S_DATA:   txd_next = shift_next[0];
            S_PARITY: txd_next = par_next;
            default:  txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd      <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            stop_cnt <= stop_next;
            txd      <= txd_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: an 8N1 and an 8E2 instance at 4 clocks per bit, with a
// frame monitor per instance checked against a queue of expected frames.
module tb_uart_tx;

    localparam int BC = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] in_data_n, in_data_e;
    logic       in_valid_n, in_valid_e;
    logic       cts_n_n, cts_n_e;
    logic       in_ready_n, in_ready_e;
    logic       txd_n, txd_e;
    logic       busy_n, busy_e;
    logic [2:0] cnt_n, cnt_e;

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLK_HZ(12_000_000),
              .BAUD_BPS(3_000_000), .FIFO_DEPTH(4)) u_n (
        .clk(clk), .resetn(resetn), .in_data(in_data_n), .in_valid(in_valid_n),
        .in_ready(in_ready_n), .cts_n(cts_n_n), .txd(txd_n), .busy(busy_n),
        .fifo_count(cnt_n)
    );

    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .CLK_HZ(12_000_000),
              .BAUD_BPS(3_000_000), .FIFO_DEPTH(4)) u_e (
        .clk(clk), .resetn(resetn), .in_data(in_data_e), .in_valid(in_valid_e),
        .in_ready(in_ready_e), .cts_n(cts_n_e), .txd(txd_e), .busy(busy_e),
        .fifo_count(cnt_e)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic [11:0] frame;
    } vec_t;
    vec_t tbl[6];

    logic [11:0] exp_n, exp_e;
    logic [11:0] q_n[$];
    logic [11:0] q_e[$];

    bit          mon_act[2];
    int          cyc[2];
    int          glitch[2];
    int          frames_seen[2];
    logic [11:0] got[2];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 0) ? in_ready_n : in_ready_e;
    endfunction

    function automatic logic bsy(input int id);
        return (id == 0) ? busy_n : busy_e;
    endfunction

    // Wire order is bit 0 first: start, data LSB..MSB, [parity], stop(s).
    function automatic logic [11:0] frame_of(input int id, input logic [7:0] d);
        if (id == 0) return {2'b00, 1'b1, d, 1'b0};
        return {2'b11, ^d, d, 1'b0};
    endfunction

    task automatic frame_done(input int id);
        logic [11:0] e;
        bit          have;
        have = 1'b0;
        e    = '0;
        if (id == 0 && q_n.size() > 0) begin
            e = q_n.pop_front();
            have = 1'b1;
        end else if (id == 1 && q_e.size() > 0) begin
            e = q_e.pop_front();
            have = 1'b1;
        end
        frames_seen[id]++;
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL frame%0d: got frame %h, expected no frame", id, got[id]);
        end else if (got[id] != e || glitch[id] != 0) begin
            errors++;
            $display("FAIL frame%0d: got %h (unstable cycles %0d), expected %h",
                     id, got[id], glitch[id], e);
        end
    endtask

    task automatic mon_step(input int id, input logic t);
        int nb;
        nb = (id == 0) ? 10 : 12;
        if (!mon_act[id]) begin
            if (t != 1'b0) return;
            mon_act[id] = 1'b1;
            cyc[id]     = 0;
            glitch[id]  = 0;
            got[id]     = '0;
        end else begin
            cyc[id]++;
        end
        if (cyc[id] % BC == 0) got[id][cyc[id] / BC] = t;
        else if (t != got[id][cyc[id] / BC]) glitch[id]++;
        if (cyc[id] == nb * BC - 1) begin
            mon_act[id] = 1'b0;
            frame_done(id);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (resetn && in_valid_n && in_ready_n) q_n.push_back(exp_n);
        if (resetn && in_valid_e && in_ready_e) q_e.push_back(exp_e);
    end

    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            mon_act[0] = 1'b0;
            mon_act[1] = 1'b0;
            q_n.delete();
            q_e.delete();
        end else begin
            mon_step(0, txd_n);
            mon_step(1, txd_e);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int id, input logic v, input logic [7:0] d, input logic [11:0] ef);
        if (id == 0) begin
            in_valid_n = v; in_data_n = d; exp_n = ef;
        end else begin
            in_valid_e = v; in_data_e = d; exp_e = ef;
        end
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic [11:0] ef);
        int n;
        n = 0;
        drive(id, 1'b1, d, ef);
        while (!rdy(id) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", rdy(id), 1);
        @(negedge clk);
        drive(id, 1'b0, d, ef);
    endtask

    task automatic wait_idle(input int id, input int limit, output int n);
        n = 0;
        while (bsy(id) && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;
    int viol;

    initial begin
        tbl[0] = '{0, 8'h5A, 12'h2B4};
        tbl[1] = '{0, 8'h00, 12'h200};
        tbl[2] = '{0, 8'hFF, 12'h3FE};
        tbl[3] = '{1, 8'h00, 12'hC00};
        tbl[4] = '{1, 8'hFF, 12'hDFE};
        tbl[5] = '{1, 8'h3C, 12'hC78};

        resetn = 1'b0;
        in_valid_n = 1'b0; in_valid_e = 1'b0;
        in_data_n = '0; in_data_e = '0;
        exp_n = '0; exp_e = '0;
        cts_n_n = 1'b1; cts_n_e = 1'b1;
        tick(3);
        resetn = 1'b1;
        tick(1);
        check("rst_txd_n", txd_n, 1);
        check("rst_busy_n", busy_n, 0);
        check("rst_ready_n", in_ready_n, 1);
        check("rst_count_n", cnt_n, 0);
        check("rst_txd_e", txd_e, 1);
        check("rst_busy_e", busy_e, 0);
        check("rst_ready_e", in_ready_e, 1);
        check("rst_count_e", cnt_e, 0);

        // Single byte 0xA5 on 8N1: start one edge after acceptance, 40 cycles long.
        cts_n_n = 1'b0;
        tick(3);
        drive(0, 1'b1, 8'hA5, 12'h34A);
        tick(1);
        drive(0, 1'b0, 8'hA5, 12'h34A);
        check("single_count_after_push", cnt_n, 1);
        check("single_busy_before_pop", busy_n, 0);
        check("single_txd_before_pop", txd_n, 1);
        tick(1);
        check("single_busy_at_pop", busy_n, 1);
        check("single_txd_start", txd_n, 0);
        check("single_count_after_pop", cnt_n, 0);
        wait_idle(0, 100, n);
        check("single_frame_cycles", n, 40);
        check("single_txd_idle", txd_n, 1);

        for (int i = 0; i < 6; i++) begin
            push(tbl[i].id, tbl[i].data, tbl[i].frame);
        end
        wait_idle(0, 400, n);
        check("table_n_drained", busy_n, 0);
        check("table_n_queue_empty", q_n.size(), 0);
        check("gated_count_e", cnt_e, 3);
        check("gated_busy_e", busy_e, 0);
        check("gated_txd_e", txd_e, 1);

        // Back-to-back 8E2 frames released by CTS: 3-edge latency, 48-cycle frames.
        cts_n_e = 1'b0;
        tick(2);
        check("b2b_busy_before_sync", busy_e, 0);
        tick(1);
        check("b2b_busy_start", busy_e, 1);
        check("b2b_txd_start1", txd_e, 0);
        check("b2b_count_2", cnt_e, 2);
        tick(48);
        check("b2b_count_1", cnt_e, 1);
        check("b2b_txd_start2", txd_e, 0);
        tick(48);
        check("b2b_count_0", cnt_e, 0);
        check("b2b_txd_start3", txd_e, 0);
        check("b2b_busy_mid", busy_e, 1);
        tick(48);
        check("b2b_busy_end", busy_e, 0);
        check("b2b_txd_end", txd_e, 1);

        // Full FIFO while CTS is not clear, then release.
        cts_n_n = 1'b1;
        tick(3);
        push(0, 8'h11, frame_of(0, 8'h11));
        push(0, 8'h22, frame_of(0, 8'h22));
        push(0, 8'h33, frame_of(0, 8'h33));
        push(0, 8'h44, frame_of(0, 8'h44));
        check("full_count", cnt_n, 4);
        check("full_ready", in_ready_n, 0);
        drive(0, 1'b1, 8'h55, frame_of(0, 8'h55));
        tick(5);
        check("full_count_held", cnt_n, 4);
        check("full_txd_idle", txd_n, 1);
        check("full_busy_idle", busy_n, 0);
        cts_n_n = 1'b0;
        tick(2);
        check("full_busy_before_sync", busy_n, 0);
        tick(1);
        check("full_busy_start", busy_n, 1);
        check("full_count_after_pop", cnt_n, 3);
        check("full_ready_after_pop", in_ready_n, 1);
        tick(1);
        drive(0, 1'b0, 8'h55, frame_of(0, 8'h55));
        check("full_fifth_accepted", cnt_n, 4);
        wait_idle(0, 300, n);
        check("full_drained", busy_n, 0);
        check("full_queue_empty", q_n.size(), 0);

        // CTS raised during the data bits of the first of two queued frames.
        push(0, 8'h69, frame_of(0, 8'h69));
        push(0, 8'h96, frame_of(0, 8'h96));
        tick(10);
        cts_n_n = 1'b1;
        wait_idle(0, 100, n);
        check("cts_frame_not_stretched", n, 30);
        check("cts_count_held", cnt_n, 1);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (txd_n != 1'b1 || busy_n != 1'b0) viol++;
        end
        check("cts_hold_idle", viol, 0);
        cts_n_n = 1'b0;
        tick(3);
        check("cts_resume_busy", busy_n, 1);
        check("cts_resume_count", cnt_n, 0);
        wait_idle(0, 100, n);
        check("cts_resume_done", busy_n, 0);

        // Reset during data bit 3 with two bytes still queued.
        push(0, 8'hA1, frame_of(0, 8'hA1));
        push(0, 8'hB2, frame_of(0, 8'hB2));
        push(0, 8'hC3, frame_of(0, 8'hC3));
        tick(16);
        check("rstmid_count_before", cnt_n, 2);
        check("rstmid_txd_bit3", txd_n, 0);
        #2;
        resetn = 1'b0;
        #1;
        check("rstmid_txd_async", txd_n, 1);
        check("rstmid_count", cnt_n, 0);
        check("rstmid_busy", busy_n, 0);
        tick(2);
        resetn = 1'b1;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (txd_n != 1'b1 || busy_n != 1'b0) viol++;
        end
        check("rstmid_nothing_sent", viol, 0);

        check("frames_total_n", frames_seen[0], 11);
        check("frames_total_e", frames_seen[1], 3);
        check("final_queue_n", q_n.size(), 0);
        check("final_queue_e", q_e.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
